// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the pipeline control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Sequencer states: normal flow, or waiting on instruction memory
    typedef enum logic {
        RUN   = 1'b0,
        IMISS = 1'b1
    } hz_state_t;

    // Default widths shared with the pipe_* register modules
    localparam int REG_ADDR_WIDTH_DFLT = 5;
    localparam int MISS_TIMEOUT_DFLT   = 64;
    localparam int CNT_WIDTH_DFLT      = 32;

    // Architectural zero register index; writes to it never create hazards
    localparam logic [REG_ADDR_WIDTH_DFLT-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the Decode sources and the Execute load destination.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall sequencer directly.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2d,
    input  logic [REG_ADDR_WIDTH-1:0] rde,
    input  logic                      loade,
    output logic                      lu
);

    logic rde_nonzero;
    logic src_match;

    assign rde_nonzero = (rde != REG_ADDR_WIDTH'(REG_ZERO));
    assign src_match   = (rde == rs1d) || (rde == rs2d);

    // A load whose result is needed by the very next instruction
    assign lu = loade && rde_nonzero && src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D and D/E pipeline registers (load-use, redirect, imem wait).
// Latency: stall/flush outputs are combinational; state, timeout flag and counters update on posedge clk.
// Backpressure: imem_ready low holds fetch and decode until it returns; optional stall_cnt under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
    parameter int MISS_TIMEOUT   = MISS_TIMEOUT_DFLT
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH      = CNT_WIDTH_DFLT
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2d,
    input  logic [REG_ADDR_WIDTH-1:0] rde,
    input  logic                      loade,
    input  logic                      pcsrce,
    input  logic                      imem_ready,
    output logic                      stallf,
    output logic                      stalld,
    output logic                      flushd,
    output logic                      flushe,
    output logic                      miss_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      stall_cnt
`endif
);

    // Wait counter holds values up to MISS_TIMEOUT-1 and then saturates
    localparam int                WAIT_W   = $clog2(MISS_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MISS_TIMEOUT - 1);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              pend_flush;
    logic              pend_nxt;
    logic              err_q;
    logic              err_nxt;

    logic              lu;
    logic              stall_raw;
    logic              flushd_raw;
    logic              flushe_raw;

    hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .rs1d  (rs1d),
        .rs2d  (rs2d),
        .rde   (rde),
        .loade (loade),
        .lu    (lu)
    );

    // State, wait counter, pending wrong-path flag and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            pend_flush <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            pend_flush <= pend_nxt;
            err_q      <= err_nxt;
        end
    end

    // Next state and hazard controls; priority is pcsrce > imem miss > load-use
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        pend_nxt   = pend_flush;
        err_nxt    = err_q;
        stall_raw  = 1'b0;
        flushd_raw = 1'b0;
        flushe_raw = 1'b0;

        case (state)
            RUN: begin
                if (!imem_ready) begin
                    // No valid instruction this cycle: hold and bubble decode.
                    // This cycle is the first wait cycle of the miss.
                    state_nxt  = IMISS;
                    wait_nxt   = WAIT_W'(1);
                    stall_raw  = 1'b1;
                    flushd_raw = 1'b1;
                    flushe_raw = lu;
                end else if (lu) begin
                    // Hold the consumer in Decode for one bubble
                    stall_raw  = 1'b1;
                    flushe_raw = 1'b1;
                end
                if (pcsrce) begin
                    // Redirect wins: the fetch/decode contents are wrong path
                    stall_raw  = 1'b0;
                    flushd_raw = 1'b1;
                    flushe_raw = 1'b1;
                end
            end

            IMISS: begin
                flushe_raw = pcsrce || lu;
                if (imem_ready) begin
                    // Line returned: release, dropping it if a redirect hit during the wait
                    state_nxt  = RUN;
                    flushd_raw = pend_flush || pcsrce;
                    pend_nxt   = 1'b0;
                    wait_nxt   = '0;
                end else begin
                    stall_raw  = 1'b1;
                    flushd_raw = 1'b1;
                    if (pcsrce) begin
                        pend_nxt = 1'b1;
                    end
                    if (wait_cnt == WAIT_MAX) begin
                        err_nxt = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Reset forces every output low independent of the registered state
    assign stallf   = stall_raw  && !rst;
    assign stalld   = stall_raw  && !rst;
    assign flushd   = flushd_raw && !rst;
    assign flushe   = flushe_raw && !rst;
    assign miss_err = err_q      && !rst;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // Free-running count of fetch-stall cycles, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stallf) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = rst ? '0 : stall_cnt_q;
`endif

endmodule
